// File: rtl/instr_register_executor.sv
// Read-side execution engine for instr_register: fetches, executes and streams results.
// Optional build macro INSTR_EXEC_DIVZERO_ERR_EN adds the res_err divide-by-zero flag port.
module instr_register_executor #(
    parameter int OP_W  = 32,
    parameter int PTR_W = 5,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [PTR_W-1:0]      first_ptr,
    input  logic [CNT_W-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic [PTR_W-1:0]      read_pointer,
    input  logic [3+2*OP_W-1:0]   instruction_word,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*OP_W-1:0]     res_data,
    output logic [PTR_W-1:0]      res_ptr,
    output logic [2:0]            res_opcode
`ifdef INSTR_EXEC_DIVZERO_ERR_EN
    ,
    output logic                  res_err
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam logic [2:0] OPC_ZERO  = 3'd0;
    localparam logic [2:0] OPC_PASSA = 3'd1;
    localparam logic [2:0] OPC_PASSB = 3'd2;
    localparam logic [2:0] OPC_ADD   = 3'd3;
    localparam logic [2:0] OPC_SUB   = 3'd4;
    localparam logic [2:0] OPC_MULT  = 3'd5;
    localparam logic [2:0] OPC_DIV   = 3'd6;
    localparam logic [2:0] OPC_MOD   = 3'd7;

    logic [1:0]              state;
    logic [CNT_W-1:0]        remaining;
    logic [2:0]              opc;
    logic [OP_W-1:0]         op_a;
    logic [OP_W-1:0]         op_b;

    logic signed [2*OP_W-1:0] a_ext;
    logic signed [2*OP_W-1:0] b_ext;
    logic signed [2*OP_W-1:0] result;
    logic                     b_zero;
    logic                     div_err;

    // Operands are widened before any arithmetic so ADD/SUB/MULT and the
    // most-negative / -1 division cannot overflow the double-width result.
    always_comb begin
        a_ext   = {{OP_W{op_a[OP_W-1]}}, op_a};
        b_ext   = {{OP_W{op_b[OP_W-1]}}, op_b};
        b_zero  = (op_b == '0);
        div_err = b_zero && ((opc == OPC_DIV) || (opc == OPC_MOD));
        result  = '0;
        case (opc)
            OPC_ZERO:  result = '0;
            OPC_PASSA: result = a_ext;
            OPC_PASSB: result = b_ext;
            OPC_ADD:   result = a_ext + b_ext;
            OPC_SUB:   result = a_ext - b_ext;
            OPC_MULT:  result = a_ext * b_ext;
            OPC_DIV:   if (!b_zero) result = a_ext / b_ext;
            OPC_MOD:   if (!b_zero) result = a_ext % b_ext;
            default:   result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            read_pointer <= '0;
            remaining    <= '0;
            opc          <= '0;
            op_a         <= '0;
            op_b         <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_ptr      <= '0;
            res_opcode   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= count;
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            read_pointer <= first_ptr;
                            busy         <= 1'b1;
                            state        <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    opc   <= instruction_word[3+2*OP_W-1 -: 3];
                    op_a  <= instruction_word[2*OP_W-1 -: OP_W];
                    op_b  <= instruction_word[OP_W-1:0];
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_data   <= result;
                    res_ptr    <= read_pointer;
                    res_opcode <= opc;
                    res_valid  <= 1'b1;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Result registers only change in EXEC, so they hold through a stall.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            read_pointer <= read_pointer + 1'b1;
                            state        <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef INSTR_EXEC_DIVZERO_ERR_EN
    logic res_err_q;
    logic err_seen;

    // err_seen is sticky across a run; res_err itself is low again by the done cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_err_q <= 1'b0;
            err_seen  <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                err_seen <= 1'b0;
            end
            if (state == ST_EXEC) begin
                res_err_q <= div_err;
                if (div_err) err_seen <= 1'b1;
            end else if ((state == ST_WAIT) && res_ready) begin
                res_err_q <= 1'b0;
            end
        end
    end

    assign res_err = res_err_q;
`endif

endmodule
